// File: rtl/sprite_anim_sequencer.sv
// Per-player sprite animation sequencer. Turns player buttons and hit events
// into frame-timed animation states. The 4-bit state code selects the sprite
// ROM that the renderer uses for this player.
// Optional build macro: ANIM_INPUT_BUFFER_EN adds a one-deep attack request
// buffer that is filled during recovery and hit-stun states.
module sprite_anim_sequencer #(
  parameter int CNT_W            = 6,
  parameter int ATK_START_FRAMES = 4,
  parameter int ATK_END_FRAMES   = 3,
  parameter int ATK_PULL_FRAMES  = 5,
  parameter int DIR_START_FRAMES = 6,
  parameter int DIR_END_FRAMES   = 4,
  parameter int DIR_PULL_FRAMES  = 8,
  parameter int HIT_FRAMES       = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_fwd,
  input  logic       btn_back,
  input  logic       btn_atk,
  input  logic       btn_dir,
  input  logic       btn_block,
  input  logic       hit_in,
  output logic [3:0] currentstate,
  output logic       attack_active,
  output logic       busy,
  output logic       blocked_pulse,
  output logic       anim_done
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WALK      = 4'd1,
    S_WALKBACK  = 4'd2,
    S_ATK_START = 4'd3,
    S_ATK_END   = 4'd4,
    S_ATK_PULL  = 4'd5,
    S_DIR_START = 4'd6,
    S_DIR_END   = 4'd7,
    S_DIR_PULL  = 4'd8,
    S_GOTHIT    = 4'd9,
    S_BLOCK     = 4'd10
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hit_pend_q;
  logic             blocked_q;
  logic             done_q;

  logic   hit_now;
  logic   is_free;
  logic   absorb;
  state_t nxt_free;
  state_t exit_sel;

  // Priority selection among the free (interruptible) states.
  function automatic state_t free_sel(input logic blk, input logic atk,
                                      input logic dir, input logic fwd,
                                      input logic back);
    if (blk)              return S_BLOCK;
    else if (atk)         return S_ATK_START;
    else if (dir)         return S_DIR_START;
    else if (fwd && !back) return S_WALK;
    else if (back && !fwd) return S_WALKBACK;
    else                  return S_IDLE;
  endfunction

  // Counter preload on entry: duration minus one, zero for free states.
  function automatic logic [CNT_W-1:0] load_of(input state_t s);
    case (s)
      S_ATK_START: return CNT_W'(ATK_START_FRAMES - 1);
      S_ATK_END:   return CNT_W'(ATK_END_FRAMES - 1);
      S_ATK_PULL:  return CNT_W'(ATK_PULL_FRAMES - 1);
      S_DIR_START: return CNT_W'(DIR_START_FRAMES - 1);
      S_DIR_END:   return CNT_W'(DIR_END_FRAMES - 1);
      S_DIR_PULL:  return CNT_W'(DIR_PULL_FRAMES - 1);
      S_GOTHIT:    return CNT_W'(HIT_FRAMES - 1);
      default:     return '0;
    endcase
  endfunction

  // A hit arriving on the tick clock itself counts for that tick.
  assign hit_now  = hit_pend_q | hit_in;
  assign is_free  = state_q inside {S_IDLE, S_WALK, S_WALKBACK, S_BLOCK};
  assign absorb   = hit_now && ((state_q == S_BLOCK) || (is_free && btn_block));
  assign nxt_free = free_sel(btn_block, btn_atk, btn_dir, btn_fwd, btn_back);

`ifdef ANIM_INPUT_BUFFER_EN
  // 0 = empty, 1 = basic attack queued, 2 = directional attack queued
  logic [1:0] buf_q;
  logic       buf_state;
  logic       buf_clear;

  assign buf_state = state_q inside {S_ATK_PULL, S_DIR_PULL, S_GOTHIT};
  assign buf_clear = frame_tick && (hit_now || (!is_free && cnt_q == '0));

  // Capture the first attack press seen while recovering; drop it when the
  // state is left or a hit lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= 2'd0;
    end else if (buf_clear) begin
      buf_q <= 2'd0;
    end else if (buf_state && buf_q == 2'd0) begin
      if (btn_atk)      buf_q <= 2'd1;
      else if (btn_dir) buf_q <= 2'd2;
    end
  end

  // Sequence exit: a queued attack beats everything except block.
  always_comb begin
    exit_sel = nxt_free;
    if (!btn_block) begin
      if (buf_q == 2'd1)      exit_sel = S_ATK_START;
      else if (buf_q == 2'd2) exit_sel = S_DIR_START;
    end
  end
`else
  // Sequence exit uses the plain free-state selection.
  always_comb begin
    exit_sel = nxt_free;
  end
`endif

  // Frame-locked animation FSM with its duration counter and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hit_pend_q <= 1'b0;
      blocked_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      blocked_q <= 1'b0;
      done_q    <= 1'b0;
      if (frame_tick) begin
        hit_pend_q <= 1'b0;
        if (hit_now && !absorb) begin
          state_q <= S_GOTHIT;
          cnt_q   <= load_of(S_GOTHIT);
        end else if (is_free) begin
          blocked_q <= absorb;
          state_q   <= nxt_free;
          cnt_q     <= load_of(nxt_free);
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          case (state_q)
            S_ATK_START: begin state_q <= S_ATK_END; cnt_q <= load_of(S_ATK_END); end
            S_ATK_END:   begin state_q <= S_ATK_PULL; cnt_q <= load_of(S_ATK_PULL); end
            S_DIR_START: begin state_q <= S_DIR_END; cnt_q <= load_of(S_DIR_END); end
            S_DIR_END:   begin state_q <= S_DIR_PULL; cnt_q <= load_of(S_DIR_PULL); end
            S_ATK_PULL, S_DIR_PULL, S_GOTHIT: begin
              state_q <= exit_sel;
              cnt_q   <= load_of(exit_sel);
              done_q  <= 1'b1;
            end
            default: begin state_q <= S_IDLE; cnt_q <= '0; end
          endcase
        end
      end else if (hit_in) begin
        hit_pend_q <= 1'b1;
      end
    end
  end

  assign currentstate  = state_q;
  assign busy          = (state_q >= S_ATK_START) && (state_q <= S_GOTHIT);
  assign attack_active = (state_q == S_ATK_END) || (state_q == S_DIR_END);
  assign blocked_pulse = blocked_q;
  assign anim_done     = done_q;

endmodule

// File: doc/sprite_anim_sequencer.md
Name: sprite_anim_sequencer

Overview:
Per-player animation controller that produces the 4-bit sprite state code selecting which sprite ROM drives the sprite renderer. It turns player inputs and hit events into timed animation sequences: attack start/end/pull, directional attack start/end/pull, hit stun, block, walk and idle. The FSM advances only on video frame ticks, so animations stay locked to the display. Two instances are built, one per player, and each feeds the renderer's state input for that player.

Parameters:
CNT_W, 6, width of the frame duration counter
ATK_START_FRAMES, 4, frames spent in ATK_START (range 1..2^CNT_W-1)
ATK_END_FRAMES, 3, frames spent in ATK_END (hit-active window)
ATK_PULL_FRAMES, 5, frames spent in ATK_PULL (recovery)
DIR_START_FRAMES, 6, frames spent in DIR_START
DIR_END_FRAMES, 4, frames spent in DIR_END (hit-active window)
DIR_PULL_FRAMES, 8, frames spent in DIR_PULL
HIT_FRAMES, 12, frames spent in GOTHIT

Ports:
clk  input  1  system/pixel clock
rst  input  1  asynchronous reset, active-high
frame_tick  input  1  one-clk pulse per video frame (start of vblank)
btn_fwd  input  1  move forward, level
btn_back  input  1  move backward, level
btn_atk  input  1  basic attack request, level
btn_dir  input  1  directional attack request, level
btn_block  input  1  block, level
hit_in  input  1  one-clk pulse: opponent attack connected
currentstate  output  4  sprite state code to the renderer
attack_active  output  1  high in ATK_END or DIR_END
busy  output  1  high in any timed state (3..9)
blocked_pulse  output  1  one-clk pulse: hit absorbed while in BLOCK
anim_done  output  1  one-clk pulse when a timed sequence returns to a free state

Behaviour:
- State codes: IDLE=0, WALK=1, WALKBACK=2, ATK_START=3, ATK_END=4, ATK_PULL=5, DIR_START=6, DIR_END=7, DIR_PULL=8, GOTHIT=9, BLOCK=10. Codes 11..15 are never produced.
- Reset values: currentstate=0, frame_cnt=0, hit_pend=0, and all other outputs 0.
- State changes happen only on a clk edge where frame_tick=1. Outputs are registered or decoded from the state register, so they change one clk after the deciding tick edge.
- hit_in is latched into sticky hit_pend on any clk and cleared on the next frame_tick edge.
  - If the current state is BLOCK, or btn_block is high while in a free state (0/1/2/10), the hit is absorbed: blocked_pulse fires on that tick edge and there is no GOTHIT.
  - Otherwise the next state is GOTHIT. This applies from any state, including mid-attack, and overrides every other request.
  - hit_in and frame_tick on the same clk: the hit counts for that tick.
- Timed states (3..9):
  - On entry, frame_cnt loads DURATION-1.
  - Each frame_tick: if frame_cnt != 0, decrement it; otherwise advance.
  - Sequences: ATK_START -> ATK_END -> ATK_PULL -> free; DIR_START -> DIR_END -> DIR_PULL -> free; GOTHIT -> free.
  - A DURATION of 1 means exactly one frame in that state.
  - GOTHIT re-entered by a new hit reloads HIT_FRAMES-1.
- Free-state selection, used on every tick from states 0/1/2/10 and at sequence exit, in priority order:
  1. btn_block -> BLOCK
  2. btn_atk -> ATK_START
  3. btn_dir -> DIR_START
  4. btn_fwd and not btn_back -> WALK
  5. btn_back and not btn_fwd -> WALKBACK
  6. otherwise IDLE
  - fwd+back together gives IDLE.
- In timed states, all buttons are ignored (no interrupt except hit). The exception is the buffering feature below.
- anim_done: one-clk pulse on the tick edge where a timed state exits to the free-state selection.
- busy = currentstate in 3..9. attack_active = state 4 or 7.
- Reset asserted mid-sequence: immediate IDLE, counter cleared, pending hit and buffer dropped.

Optional Feature:
ANIM_INPUT_BUFFER_EN
- Defined: a one-deep buffer records the first btn_atk or btn_dir seen high during ATK_PULL, DIR_PULL or GOTHIT. btn_atk wins if both are seen on the same clk.
  - On exit from that state, a buffered request starts ATK_START or DIR_START directly, overriding the free-state selection except btn_block.
  - The buffer clears on use, on a hit, and on reset.
- Undefined: no buffer; presses in timed states are ignored.

Test Plan:
- Reset, then no inputs with 10 ticks -> currentstate=0, busy=0, all pulses 0.
- btn_atk held one tick with defaults -> states 3 for 4 ticks, 4 for 3 ticks (attack_active=1), 5 for 5 ticks, then 0. anim_done pulses once at the return to 0.
- hit_in during ATK_END (frame 2) -> next tick gives 9. It holds for 12 ticks, then follows the free selection (btn_fwd=1 gives 1).
- btn_block held, state 10, hit_in pulse -> blocked_pulse=1 for one clk, state stays 10. The same hit in state 1 with btn_block=0 -> state 9.
- btn_fwd=1 and btn_back=1 -> state 0. btn_back alone -> 2. btn_atk and btn_dir together -> 3.
- With ANIM_INPUT_BUFFER_EN, btn_dir pulsed during ATK_PULL -> after the pull, state goes 5 -> 6 with no IDLE frame. Without the macro -> 5 -> 0.
